// File: rtl/reg_dr_gen.sv
// Loadable up/down register with a small save/restore stack.
// Configurable width, stack depth, and wrap-around or saturating arithmetic.
module reg_dr_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SAT   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       ld,
  input  logic                       inc,
  input  logic                       dec,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic                       zero,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     stk_cnt,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stk_q [DEPTH];

  logic          full, empty;
  logic          push_ok, pop_ok;
  logic [AW-1:0] push_idx, pop_idx;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_idx = AW'(cnt_q);
  assign pop_idx  = AW'(cnt_q - CW'(1));

  // Simultaneous push and pop cancel each other and count as an error.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;

  always_comb begin
    data_d = data_q;
    ovf_d  = 1'b0;
    cnt_d  = cnt_q;
    err_d  = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

    if (push_ok)
      cnt_d = cnt_q + CW'(1);
    else if (pop_ok)
      cnt_d = cnt_q - CW'(1);

    // A pop overridden by clr/ld still consumes its entry through cnt_d above.
    if (clr) begin
      data_d = '0;
    end else if (ld) begin
      data_d = data_in;
    end else if (pop_ok) begin
      data_d = stk_q[pop_idx];
    end else if (inc && !dec) begin
      if (data_q == '1) begin
        ovf_d = 1'b1;
        if (SAT == 0) data_d = '0;
      end else begin
        data_d = data_q + WIDTH'(1);
      end
    end else if (dec && !inc) begin
      if (data_q == '0) begin
        ovf_d = 1'b1;
        if (SAT == 0) data_d = '1;
      end else begin
        data_d = data_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  // Stack storage has no reset; entries at or above the count are don't-care.
  always_ff @(posedge clk) begin
    if (push_ok) stk_q[push_idx] <= data_q;
  end

  assign data_out  = data_q;
  assign zero      = (data_q == '0);
  assign ovf       = ovf_q;
  assign stk_cnt   = cnt_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_dr_gen.sv
// Directed bench for reg_dr_gen: a wrap-around and a saturating instance
// (WIDTH=8, DEPTH=4) share the same stimulus.
module tb_reg_dr_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       ld, inc, dec, clr, push, pop;

  logic [7:0] w_data, s_data;
  logic       w_zero, s_zero, w_ovf, s_ovf, w_full, s_full, w_empty, s_empty, w_err, s_err;
  logic [2:0] w_cnt, s_cnt;

  int checks = 0;
  int errors = 0;

  reg_dr_gen #(.WIDTH(8), .DEPTH(4), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
    .clr(clr), .push(push), .pop(pop), .data_out(w_data), .zero(w_zero), .ovf(w_ovf),
    .stk_cnt(w_cnt), .stk_full(w_full), .stk_empty(w_empty), .err(w_err)
  );

  reg_dr_gen #(.WIDTH(8), .DEPTH(4), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
    .clr(clr), .push(push), .pop(pop), .data_out(s_data), .zero(s_zero), .ovf(s_ovf),
    .stk_cnt(s_cnt), .stk_full(s_full), .stk_empty(s_empty), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ld = 0; inc = 0; dec = 0; clr = 0; push = 0; pop = 0;
  endtask

  // Apply the current inputs across one rising edge, then release them.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load(input logic [7:0] v);
    data_in = v; ld = 1; tick();
  endtask

  initial begin
    rst_n = 0; data_in = '0; idle();
    #3;
    chk("rst_data", w_data, 8'h00);
    chk("rst_zero", w_zero, 1'b1);
    chk("rst_empty", w_empty, 1'b1);
    chk("rst_full", w_full, 1'b0);
    chk("rst_cnt", w_cnt, 3'd0);
    chk("rst_ovf", w_ovf, 1'b0);
    chk("rst_err", w_err, 1'b0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // Overflow at the top of range
    load(8'hFF);
    chk("ld_ff", w_data, 8'hFF);
    inc = 1; tick();
    chk("wrap_inc_data", w_data, 8'h00);
    chk("wrap_inc_ovf", w_ovf, 1'b1);
    chk("wrap_inc_zero", w_zero, 1'b1);
    chk("sat_inc_data", s_data, 8'hFF);
    chk("sat_inc_ovf", s_ovf, 1'b1);
    tick();
    chk("ovf_one_pulse", w_ovf, 1'b0);
    dec = 1; tick();
    chk("wrap_dec_data", w_data, 8'hFF);
    chk("wrap_dec_ovf", w_ovf, 1'b1);
    chk("sat_dec_norm", s_data, 8'hFE);
    chk("sat_dec_noovf", s_ovf, 1'b0);

    // Underflow at zero
    clr = 1; tick();
    chk("clr_data", s_data, 8'h00);
    dec = 1; tick();
    chk("sat_dec0_data", s_data, 8'h00);
    chk("sat_dec0_ovf", s_ovf, 1'b1);
    chk("wrap_dec0_data", w_data, 8'hFF);
    chk("wrap_dec0_ovf", w_ovf, 1'b1);

    // Fill and drain the stack
    clr = 1; tick();
    load(8'h11); push = 1; tick();
    load(8'h22); push = 1; tick();
    load(8'h33); push = 1; tick();
    load(8'h44); push = 1; tick();
    chk("fill_cnt", w_cnt, 3'd4);
    chk("fill_full", w_full, 1'b1);
    chk("fill_err", w_err, 1'b0);
    push = 1; tick();
    chk("over_push_err", w_err, 1'b1);
    chk("over_push_cnt", w_cnt, 3'd4);
    pop = 1; tick();
    chk("pop1_data", w_data, 8'h44);
    chk("pop1_cnt", w_cnt, 3'd3);
    chk("pop1_err", w_err, 1'b0);
    pop = 1; tick();
    chk("pop2_data", w_data, 8'h33);
    pop = 1; tick();
    chk("pop3_data", w_data, 8'h22);
    pop = 1; tick();
    chk("pop4_data", w_data, 8'h11);
    chk("pop4_empty", w_empty, 1'b1);
    pop = 1; tick();
    chk("under_pop_err", w_err, 1'b1);
    chk("under_pop_data", w_data, 8'h11);
    chk("under_pop_cnt", w_cnt, 3'd0);

    // Push saves the pre-edge value
    load(8'h05);
    push = 1; inc = 1; tick();
    chk("push_inc_data", w_data, 8'h06);
    chk("push_inc_cnt", w_cnt, 3'd1);
    pop = 1; tick();
    chk("pop_old_data", w_data, 8'h05);
    chk("pop_old_cnt", w_cnt, 3'd0);

    // Priority
    load(8'hFF);
    clr = 1; data_in = 8'h3C; ld = 1; inc = 1; tick();
    chk("clr_pri_data", w_data, 8'h00);
    chk("clr_pri_ovf", w_ovf, 1'b0);
    data_in = 8'h3C; ld = 1; inc = 1; tick();
    chk("ld_pri_data", w_data, 8'h3C);
    inc = 1; dec = 1; tick();
    chk("incdec_hold", w_data, 8'h3C);
    chk("incdec_ovf", w_ovf, 1'b0);
    push = 1; tick();
    push = 1; pop = 1; tick();
    chk("pushpop_err", w_err, 1'b1);
    chk("pushpop_cnt", w_cnt, 3'd1);
    chk("pushpop_data", w_data, 8'h3C);
    data_in = 8'h99; ld = 1; pop = 1; tick();
    chk("ld_pop_data", w_data, 8'h99);
    chk("ld_pop_cnt", w_cnt, 3'd0);
    pop = 1; inc = 1; tick();
    chk("empty_pop_inc_data", w_data, 8'h9A);
    chk("empty_pop_inc_err", w_err, 1'b1);
    clr = 1; dec = 1; tick();
    chk("clr_dec_ovf", w_ovf, 1'b0);

    // Asynchronous reset mid-cycle
    load(8'h01); push = 1; tick();
    load(8'h02); push = 1; tick();
    load(8'h03); push = 1; tick();
    data_in = 8'h7A; ld = 1; push = 1; pop = 1; tick();
    chk("pre_rst_data", w_data, 8'h7A);
    chk("pre_rst_cnt", w_cnt, 3'd3);
    chk("pre_rst_err", w_err, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("async_data", w_data, 8'h00);
    chk("async_cnt", w_cnt, 3'd0);
    chk("async_err", w_err, 1'b0);
    chk("async_zero", w_zero, 1'b1);
    chk("async_empty", w_empty, 1'b1);
    @(negedge clk); rst_n = 1;
    pop = 1; tick();
    chk("post_rst_pop_err", w_err, 1'b1);
    chk("post_rst_pop_data", w_data, 8'h00);
    chk("post_rst_pop_cnt", w_cnt, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
